// File: rtl/ecb_row_decrypt.sv
// Row-oriented ECB decryptor: each ciphertext word is XORed with a per-row key,
// streamed out through a one-word output register with valid/ready handshakes.
module ecb_row_decrypt #(
    parameter int BLOCK_SIZE = 32,
    parameter int HSIZE      = 768
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BLOCK_SIZE-1:0] key,
    input  logic                  key_load,
    input  logic                  ct_valid,
    output logic                  ct_ready,
    input  logic [BLOCK_SIZE-1:0] ct_data,
    output logic                  pt_valid,
    input  logic                  pt_ready,
    output logic [BLOCK_SIZE-1:0] pt_data,
    output logic                  pt_last,
    output logic                  row_done,
    output logic                  busy
);
    localparam int WORDS = HSIZE / BLOCK_SIZE;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_reg;
    logic [BLOCK_SIZE-1:0] key_reg;
    logic [CNT_W-1:0]      word_cnt_reg;
    logic [BLOCK_SIZE-1:0] plain_word;
    logic                  key_take;
    logic                  ct_accept;
    logic                  pt_fire;

    // Key bit i decrypts data bit i.
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_xor
        assign plain_word[gi] = ct_data[gi] ^ key_reg[gi];
    end

    // A key reload is only honoured at a row boundary and steals that cycle's accept slot.
    always_comb begin
        key_take  = key_load && (word_cnt_reg == '0);
        ct_ready  = (state_reg == RUN) && (!pt_valid || pt_ready) && !key_take;
        ct_accept = ct_valid && ct_ready;
        pt_fire   = pt_valid && pt_ready;
        busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            key_reg      <= '0;
            word_cnt_reg <= '0;
            pt_valid     <= 1'b0;
            pt_data      <= '0;
            pt_last      <= 1'b0;
            row_done     <= 1'b0;
        end else begin
            row_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (key_load) begin
                        key_reg      <= key;
                        word_cnt_reg <= '0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    if (key_take) begin
                        key_reg <= key;
                    end
                    if (ct_accept) begin
                        pt_data  <= plain_word;
                        pt_valid <= 1'b1;
                        pt_last  <= (word_cnt_reg == LAST_IDX);
                        if (word_cnt_reg == LAST_IDX) begin
                            word_cnt_reg <= '0;
                            state_reg    <= DRAIN;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                        end
                    end else if (pt_fire) begin
                        pt_valid <= 1'b0;
                        pt_last  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Only the row's last word can be in the output register here.
                    if (pt_fire) begin
                        pt_valid  <= 1'b0;
                        pt_last   <= 1'b0;
                        row_done  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
